// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and sizing for the digit-serial subtractor
// Purpose: FSM state encoding, default operand/digit widths, derived digit
//          count and counter width.
// Ports:   none (package).
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  // A single-digit operation still needs a 1-bit counter to keep widths legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_N     = DEF_WIDTH / DEF_DIGIT;
  localparam int DEF_CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/sub_digit_4bit.sv
// rtl/sub_digit_4bit.sv - combinational DIGIT-bit borrow-propagate slice
// Purpose: {b_o, d} = x - y - b_i, formed as x + ~y + ~b_i.
// Ports:   x, y  in  DIGIT  minuend / subtrahend digit
//          b_i   in  1      borrow in
//          d     out DIGIT  difference digit
//          b_o   out 1      borrow out
module sub_digit_4bit
  import sub_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             b_i,
  output logic [DIGIT-1:0] d,
  output logic             b_o
);

  // DIGIT+1 bit sum: the MSB is the carry, i.e. the inverted borrow.
  logic [DIGIT:0] sum;

  assign sum = {1'b0, x} + {1'b0, ~y} + {{DIGIT{1'b0}}, ~b_i};
  assign d   = sum[DIGIT-1:0];
  assign b_o = ~sum[DIGIT];

endmodule

// File: rtl/serial_subtractor_16bit.sv
// rtl/serial_subtractor_16bit.sv - digit-serial subtractor D = A - B - b_in
// Purpose: one DIGIT-wide slice per clock through a single borrow slice, with a
//          start/done handshake. Optional signed-overflow flag under macro
//          SUB_OVF_FLAG_EN.
// Ports:   clk, rst_n (sync, active-low), start, A, B, b_in (captured on accept)
//          busy (RUN), done (one-cycle pulse), D, b_out, ovf (SUB_OVF_FLAG_EN only)
module serial_subtractor_16bit
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             b_out
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, d_q, d_d;
  logic             borrow_q, borrow_d, b_out_q, b_out_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SUB_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] x_k, y_k, d_k;
  logic             bo_k;
  logic [WIDTH-1:0] res_upd;
  int               base;

  // Select slice k of the latched operands.
  always_comb begin
    base = int'(cnt_q) * DIGIT;
    x_k  = a_q[base +: DIGIT];
    y_k  = b_q[base +: DIGIT];
  end

  sub_digit_4bit #(.DIGIT(DIGIT)) u_slice (
    .x   (x_k),
    .y   (y_k),
    .b_i (borrow_q),
    .d   (d_k),
    .b_o (bo_k)
  );

  // Result with the current digit merged in; on the last digit this is D.
  always_comb begin
    res_upd = res_q;
    res_upd[base +: DIGIT] = d_k;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    b_out_d  = b_out_q;
    cnt_d    = cnt_q;
`ifdef SUB_OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          a_d      = A;
          b_d      = B;
          borrow_d = b_in;
          cnt_d    = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d    = res_upd;
        borrow_d = bo_k;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          d_d     = res_upd;
          b_out_d = bo_k;
          cnt_d   = '0;
`ifdef SUB_OVF_FLAG_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_upd[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SUB_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      b_out_q  <= b_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
`ifdef SUB_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign D     = d_q;
  assign b_out = b_out_q;
`ifdef SUB_OVF_FLAG_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb/tb_serial_subtractor_16bit.sv - self-checking bench for serial_subtractor_16bit
module tb_serial_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A_i = '0;
  logic [15:0] B_i = '0;
  logic        bin_i = 1'b0;
  logic        busy, done, b_out;
  logic [15:0] D;
`ifdef SUB_OVF_FLAG_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A_i),
    .B     (B_i),
    .b_in  (bin_i),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .b_out (b_out)
`ifdef SUB_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Plain-arithmetic reference.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic ov);
    int diff, sdiff;
    diff  = int'(a) - int'(b) - int'(bin);
    sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d     = diff[15:0];
    bo    = (diff < 0);
    ov    = (sdiff > 32767) || (sdiff < -32768);
  endtask

  // Counts rising edges until done is seen (sampled 1 time unit after the edge).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int lat);
    A_i = a;
    B_i = b;
    bin_i = bin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(lat);
  endtask

  task automatic check_ovf(input string name, input logic exp);
`ifdef SUB_OVF_FLAG_EN
    check(name, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  initial begin
    int          lat;
    logic [15:0] ed;
    logic        ebo, eov;
    logic [15:0] ra, rb;
    logic        rbin;

    vecs[0] = '{"t1_basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{"t2_wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{"t2_bin",     16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{"t3_ovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{"all_ones",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{"digits",     16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_D", {16'd0, D}, 32'd0);
    check("reset_bout", {31'd0, b_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check({vecs[i].name, "_lat"}, lat, 32'd4);
      check({vecs[i].name, "_D"}, {16'd0, D}, {16'd0, vecs[i].d});
      check({vecs[i].name, "_bout"}, {31'd0, b_out}, {31'd0, vecs[i].bo});
      check_ovf({vecs[i].name, "_ovf"}, vecs[i].ov);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_D_hold"}, {16'd0, D}, {16'd0, vecs[i].d});
    end

    // Start during RUN is ignored.
    A_i = 16'h00FF; B_i = 16'h000F; bin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    A_i = 16'hFFFF; B_i = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat);
    check("t4_lat", lat + 2, 32'd4);
    check("t4_D", {16'd0, D}, 32'h00F0);
    check("t4_bout", {31'd0, b_out}, 32'd0);
    @(posedge clk); #1;
    check("t4_idle_after", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN.
    A_i = 16'h1234; B_i = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_D", {16'd0, D}, 32'd0);
    check("t5_bout", {31'd0, b_out}, 32'd0);
    rst_n = 1'b1;
    run_op(16'h4321, 16'h1111, 1'b0, lat);
    check("t5_new_lat", lat, 32'd4);
    check("t5_new_D", {16'd0, D}, 32'h3210);

    // Back-to-back accept while in DONE.
    run_op(16'h0100, 16'h0001, 1'b0, lat);
    check("t6_first_D", {16'd0, D}, 32'h00FF);
    A_i = 16'h0010; B_i = 16'h0011; bin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("t6_spacing", lat + 1, 32'd5);
    check("t6_D", {16'd0, D}, 32'hFFFF);
    check("t6_bout", {31'd0, b_out}, 32'd1);

    // Randomized operations against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (k < 4) begin
        ra = (k[0]) ? 16'hFFFF : 16'h0000;
        rb = (k[1]) ? 16'hFFFF : 16'h0000;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      model(ra, rb, rbin, ed, ebo, eov);
      run_op(ra, rb, rbin, lat);
      check($sformatf("rnd%0d_lat", k), lat, 32'd4);
      check($sformatf("rnd%0d_D", k), {16'd0, D}, {16'd0, ed});
      check($sformatf("rnd%0d_bout", k), {31'd0, b_out}, {31'd0, ebo});
      check_ovf($sformatf("rnd%0d_ovf", k), eov);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
